// File: rtl/instr_fetch.sv
// 8080-style instruction fetch: reads an opcode plus 0-2 immediate bytes and presents the
// instruction in HOLD. Optional interrupt injection is enabled by defining I8080_INTR_EN.
module instr_fetch #(
    parameter int XLEN = 8,
    parameter int ALEN = 16
) (
    input  logic            clk,
    input  logic            rst,
    output logic [ALEN-1:0] mem_addr,
    output logic            mem_rd,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    input  logic            pc_load,
    input  logic [ALEN-1:0] pc_load_addr,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [ALEN-1:0] imm,
    output logic [ALEN-1:0] instr_pc,
    input  logic            intr_req,
    input  logic            inte,
    input  logic [2:0]      intr_vec,
    output logic            intr_ack
);

    typedef enum logic [1:0] {OP, IMM_LO, IMM_HI, HOLD} state_t;

    state_t          r_state, w_state_nxt;
    logic [ALEN-1:0] r_pc, w_pc_nxt, w_pc_inc;
    logic [XLEN-1:0] r_instr, w_instr_nxt;
    logic [ALEN-1:0] r_imm, w_imm_nxt;
    logic [ALEN-1:0] r_instr_pc, w_instr_pc_nxt;
    logic            r_valid, w_valid_nxt;
    logic            r_three, w_three_nxt;
    logic [1:0]      w_len;
    logic            w_take_intr;
    logic [XLEN-1:0] w_intr_op;

    // Total instruction length in bytes, decoded from the opcode.
    function automatic logic [1:0] op_len(input logic [7:0] op);
        casez (op)
            8'b00??0001, 8'h22, 8'h2A, 8'h32, 8'h3A,
            8'hC3, 8'hCD, 8'b11???010, 8'b11???100: op_len = 2'd3;
            8'b00???110, 8'b11???110, 8'hD3, 8'hDB:  op_len = 2'd2;
            default:                                 op_len = 2'd1;
        endcase
    endfunction

`ifdef I8080_INTR_EN
    assign w_take_intr = (r_state == OP) & intr_req & inte & ~pc_load;
    assign intr_ack    = w_take_intr & ~rst;
    assign w_intr_op   = XLEN'({2'b11, intr_vec, 3'b111});
`else
    logic w_unused_intr;
    assign w_unused_intr = ^{intr_req, inte, intr_vec};
    assign w_take_intr   = 1'b0;
    assign intr_ack      = 1'b0;
    assign w_intr_op     = '0;
`endif

    assign w_pc_inc    = r_pc + ALEN'(1);
    assign w_len       = op_len(mem_rdata[7:0]);
    assign mem_addr    = r_pc;
    assign mem_rd      = ~rst & (r_state != HOLD) & ~w_take_intr;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign imm         = r_imm;
    assign instr_pc    = r_instr_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= OP;
            r_pc       <= '0;
            r_instr    <= '0;
            r_imm      <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_three    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_imm      <= w_imm_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_valid    <= w_valid_nxt;
            r_three    <= w_three_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_imm_nxt      = r_imm;
        w_instr_pc_nxt = r_instr_pc;
        w_valid_nxt    = r_valid;
        w_three_nxt    = r_three;
        // A redirect overrides everything, including a handshake in the same cycle.
        if (pc_load) begin
            w_state_nxt = OP;
            w_pc_nxt    = pc_load_addr;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                OP: begin
                    if (w_take_intr) begin
                        w_instr_nxt    = w_intr_op;
                        w_imm_nxt      = '0;
                        w_instr_pc_nxt = r_pc;
                        w_state_nxt    = HOLD;
                        w_valid_nxt    = 1'b1;
                    end else if (mem_ready) begin
                        w_instr_nxt = mem_rdata;
                        w_imm_nxt   = '0;
                        w_pc_nxt    = w_pc_inc;
                        w_three_nxt = (w_len == 2'd3);
                        if (w_len == 2'd1) begin
                            w_instr_pc_nxt = w_pc_inc;
                            w_state_nxt    = HOLD;
                            w_valid_nxt    = 1'b1;
                        end else begin
                            w_state_nxt = IMM_LO;
                        end
                    end
                end
                IMM_LO: begin
                    if (mem_ready) begin
                        w_imm_nxt = ALEN'(mem_rdata);
                        w_pc_nxt  = w_pc_inc;
                        if (r_three) begin
                            w_state_nxt = IMM_HI;
                        end else begin
                            w_instr_pc_nxt = w_pc_inc;
                            w_state_nxt    = HOLD;
                            w_valid_nxt    = 1'b1;
                        end
                    end
                end
                IMM_HI: begin
                    if (mem_ready) begin
                        w_imm_nxt      = ALEN'({mem_rdata, r_imm[XLEN-1:0]});
                        w_pc_nxt       = w_pc_inc;
                        w_instr_pc_nxt = w_pc_inc;
                        w_state_nxt    = HOLD;
                        w_valid_nxt    = 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        w_state_nxt = OP;
                        w_valid_nxt = 1'b0;
                    end
                end
                default: w_state_nxt = OP;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: byte-wide memory model, table of instructions,
// and hand sequences for stalls, hold, redirects, reset and interrupt injection.
module tb_instr_fetch;
    localparam int XLEN = 8;
    localparam int ALEN = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [ALEN-1:0] mem_addr;
    logic            mem_rd;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;
    logic            pc_load;
    logic [ALEN-1:0] pc_load_addr;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [ALEN-1:0] imm;
    logic [ALEN-1:0] instr_pc;
    logic            intr_req;
    logic            inte;
    logic [2:0]      intr_vec;
    logic            intr_ack;

    logic [7:0] mem [0:65535];
    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    instr_fetch #(.XLEN(XLEN), .ALEN(ALEN)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc_load(pc_load),
        .pc_load_addr(pc_load_addr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .imm(imm), .instr_pc(instr_pc), .intr_req(intr_req),
        .inte(inte), .intr_vec(intr_vec), .intr_ack(intr_ack)
    );

    typedef struct {
        logic [7:0]  instr;
        logic [15:0] imm;
        logic [15:0] ipc;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  b0, b1, b2;
        logic [7:0]  e_instr;
        logic [15:0] e_imm, e_pc;
        int          e_lat;
    } vec_t;

    exp_t sb[$];
    vec_t vt[13];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] i, input logic [15:0] m, input logic [15:0] p);
        exp_t e;
        e.instr = i; e.imm = m; e.ipc = p;
        sb.push_back(e);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!instr_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        if (!instr_valid) check("valid_timeout", {31'b0, instr_valid}, 32'd1);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, sb.size(), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_instr"}, instr, e.instr);
            check({tag, "_imm"}, imm, e.imm);
            check({tag, "_pc"}, instr_pc, e.ipc);
        end
    endtask

    task automatic redirect(input logic [15:0] a);
        pc_load = 1'b1;
        pc_load_addr = a;
        tick();
        pc_load = 1'b0;
    endtask

    task automatic accept();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [15:0] a;
        logic [7:0]  h_instr;
        logic [15:0] h_imm, h_pc;

        vt[0]  = '{16'h0100, 8'h01, 8'h34, 8'h12, 8'h01, 16'h1234, 16'h0103, 3};
        vt[1]  = '{16'h0200, 8'h06, 8'h77, 8'h00, 8'h06, 16'h0077, 16'h0202, 2};
        vt[2]  = '{16'h0300, 8'hCB, 8'h55, 8'h66, 8'hCB, 16'h0000, 16'h0301, 1};
        vt[3]  = '{16'h0310, 8'hD3, 8'hAA, 8'h00, 8'hD3, 16'h00AA, 16'h0312, 2};
        vt[4]  = '{16'h0320, 8'hCD, 8'h78, 8'h56, 8'hCD, 16'h5678, 16'h0323, 3};
        vt[5]  = '{16'h0330, 8'h08, 8'h99, 8'h99, 8'h08, 16'h0000, 16'h0331, 1};
        vt[6]  = '{16'h0340, 8'hFE, 8'h11, 8'h00, 8'hFE, 16'h0011, 16'h0342, 2};
        vt[7]  = '{16'h0350, 8'hE2, 8'hEF, 8'hBE, 8'hE2, 16'hBEEF, 16'h0353, 3};
        vt[8]  = '{16'h0360, 8'hDD, 8'h21, 8'h00, 8'hDD, 16'h0000, 16'h0361, 1};
        vt[9]  = '{16'h0370, 8'h2A, 8'h00, 8'h80, 8'h2A, 16'h8000, 16'h0373, 3};
        vt[10] = '{16'h0380, 8'h76, 8'h00, 8'h00, 8'h76, 16'h0000, 16'h0381, 1};
        vt[11] = '{16'h0390, 8'hD9, 8'h00, 8'h00, 8'hD9, 16'h0000, 16'h0391, 1};
        vt[12] = '{16'hFFFF, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 1};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        rst = 1'b1; pc_load = 1'b0; pc_load_addr = '0; instr_ready = 1'b0;
        mem_ready = 1'b1; intr_req = 1'b0; inte = 1'b0; intr_vec = 3'd0;
        mem[0] = 8'h3E; mem[1] = 8'h5A;
        repeat (3) tick();

        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_imm", imm, 0);
        check("rst_ipc", instr_pc, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_intr_ack", intr_ack, 0);
        check("rst_addr", mem_addr, 0);

        // 2-byte MVI A at 0000 straight out of reset
        rst = 1'b0;
        #1;
        check("first_rd", mem_rd, 1);
        check("first_addr", mem_addr, 0);
        push(8'h3E, 16'h005A, 16'h0002);
        wait_valid(c);
        check("lat_mvi", c, 2);
        check_out("mvi");

        // consumer stalls for 4 cycles
        h_instr = instr; h_imm = imm; h_pc = instr_pc;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_valid", instr_valid, 1);
            check("hold_mem_rd", mem_rd, 0);
            check("hold_addr", mem_addr, 16'h0002);
            check("hold_stable", {instr, imm}, {h_instr, h_imm});
            check("hold_pc", instr_pc, h_pc);
        end
        accept();
        check("after_hold_addr", mem_addr, 16'h0002);
        check("after_hold_rd", mem_rd, 1);

        for (int i = 0; i < 13; i++) begin
            a = vt[i].addr;
            mem[a] = vt[i].b0;
            a = a + 16'd1; mem[a] = vt[i].b1;
            a = a + 16'd1; mem[a] = vt[i].b2;
            redirect(vt[i].addr);
            push(vt[i].e_instr, vt[i].e_imm, vt[i].e_pc);
            wait_valid(c);
            check($sformatf("lat_v%0d", i), c, vt[i].e_lat);
            check_out($sformatf("v%0d", i));
            accept();
            check($sformatf("next_addr_v%0d", i), mem_addr, vt[i].e_pc);
        end

        // redirect in the middle of a 3-byte fetch
        mem[16'h0500] = 8'hC3; mem[16'h0501] = 8'h11; mem[16'h0502] = 8'h22;
        redirect(16'h0500);
        tick();
        check("mid_addr", mem_addr, 16'h0501);
        pc_load = 1'b1; pc_load_addr = 16'h0100;
        tick();
        pc_load = 1'b0;
        check("redir_addr", mem_addr, 16'h0100);
        check("redir_valid", instr_valid, 0);
        push(8'h01, 16'h1234, 16'h0103);
        wait_valid(c);
        check("lat_redir", c, 3);
        check_out("redir");

        // handshake coinciding with a redirect is dropped
        instr_ready = 1'b1; pc_load = 1'b1; pc_load_addr = 16'h0200;
        tick();
        instr_ready = 1'b0; pc_load = 1'b0;
        check("coin_valid", instr_valid, 0);
        check("coin_addr", mem_addr, 16'h0200);
        check("coin_rd", mem_rd, 1);
        push(8'h06, 16'h0077, 16'h0202);
        wait_valid(c);
        check_out("coin");
        accept();

        // reset while fetching, then a stalled 3-byte JMP at 0000
        redirect(16'h0500);
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_rd", mem_rd, 0);
        check("rst_mid_addr", mem_addr, 0);
        check("rst_mid_valid", instr_valid, 0);
        mem[0] = 8'hC3; mem[1] = 8'h34; mem[2] = 8'h12;
        tick();
        rst = 1'b0;
        push(8'hC3, 16'h1234, 16'h0003);
        c = 0;
        while (!instr_valid && c < 20) begin
            mem_ready = !(c == 1 || c == 2);
            #1;
            if (c == 2) check("stall_addr", mem_addr, 16'h0001);
            tick();
            c++;
        end
        mem_ready = 1'b1;
        check("lat_stall", c, 5);
        check_out("jmp");
        accept();

`ifdef I8080_INTR_EN
        redirect(16'h0040);
        intr_req = 1'b1; inte = 1'b1; intr_vec = 3'd7;
        #1;
        check("intr_ack_pulse", intr_ack, 1);
        check("intr_no_rd", mem_rd, 0);
        push(8'hFF, 16'h0000, 16'h0040);
        tick();
        intr_req = 1'b0;
        check("intr_ack_end", intr_ack, 0);
        check("intr_valid", instr_valid, 1);
        check_out("intr");
        accept();
        check("intr_pc_kept", mem_addr, 16'h0040);
`else
        mem[16'h0040] = 8'h00;
        redirect(16'h0040);
        intr_req = 1'b1; inte = 1'b1; intr_vec = 3'd7;
        #1;
        check("intr_ignored_ack", intr_ack, 0);
        check("intr_ignored_rd", mem_rd, 1);
        push(8'h00, 16'h0000, 16'h0041);
        wait_valid(c);
        check("intr_ignored_lat", c, 1);
        check_out("nointr");
        intr_req = 1'b0;
        accept();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
